// File: rtl/fetch_buffer_pkg.sv
// Shared constants for the instruction-fetch front end.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fetch_buffer_pkg;

   // Every instruction occupies one 32-bit word.
   localparam int          INSTR_BYTES      = 4;
   // The canonical no-op (addi x0, x0, 0), shown when nothing is valid.
   localparam logic [31:0] NOP_INSTR        = 32'h00000013;
   localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-side bus bundle: instruction SRAM port plus the decode handshake.
// Latency: n/a (wiring only).
// Backpressure: out_ready from decode stalls the head entry.
interface fetch_buffer_if #(
   parameter int PC_W    = 64,
   parameter int INSTR_W = 32
);

   logic [PC_W-1:0]    imem_addr;
   logic               imem_ren;
   logic [INSTR_W-1:0] imem_rdata;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc;

   // Fetch buffer side.
   modport master (
      output imem_addr, imem_ren, out_valid, out_instr, out_pc,
      input  imem_rdata, out_ready
   );

   // SRAM/decode side.
   modport slave (
      input  imem_addr, imem_ren, out_valid, out_instr, out_pc,
      output imem_rdata, out_ready
   );

endinterface

// File: rtl/fetch_buffer_fifo.sv
// Generic synchronous FIFO with clear, occupancy count and async active-low reset.
// Latency: a push is visible at pop_data the cycle after it is written.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module sync_fifo_arstn #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Storage array; no reset needed since count gates visibility.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; clear wins over push/pop.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (!push && pop) count <= count - CNT_W'(1);
      end
   end

   assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction-fetch front end: owns the fetch PC, reads a 1-cycle SRAM, queues {pc,instr}.
// Latency: issue at T, head valid at T+2 (T+1 with FETCH_BUFFER_BYPASS_EN defined).
// Backpressure: out_ready low holds the head; issue stops once queued + in-flight reaches DEPTH.
module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter  int              PC_W     = 64,
   parameter  int              INSTR_W  = 32,
   parameter  int              DEPTH    = 4,
   parameter  logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC),
   localparam int              CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              enable,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic [CNT_W-1:0]  count,
   fetch_buffer_if.master    bus
);

   localparam int ENTRY_W = INSTR_W + PC_W;

   logic [PC_W-1:0]    fetch_pc;
   logic [PC_W-1:0]    inflight_pc;
   logic               inflight;
   logic [PC_W-1:0]    redirect_target;
   logic [CNT_W-1:0]   fifo_count;
   logic [ENTRY_W-1:0] head_dat;
   logic [CNT_W:0]     occupancy;
   logic               head_vld;
   logic               push;
   logic               byp;
   logic               pop;
   logic               issue;
   logic               fifo_push;
   logic               fifo_pop;

   // Instruction addresses are word aligned; low two bits of the target are dropped.
   assign redirect_target = redirect_pc & ~PC_W'(3);

   // Handshake and issue control; a redirect suppresses issue, pop and the returning push.
   always_comb begin
      head_vld = (fifo_count != '0);
      push     = inflight & !redirect_valid;
`ifdef FETCH_BUFFER_BYPASS_EN
      // Empty queue: present the returning word straight to decode.
      byp      = (fifo_count == '0) & push;
`else
      byp      = 1'b0;
`endif
      pop       = (head_vld | byp) & bus.out_ready & enable & !redirect_valid;
      occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
      issue     = enable & !redirect_valid & (occupancy < (CNT_W + 1)'(DEPTH));
      // A bypassed word that decode takes immediately never enters the queue.
      fifo_push = push & !(byp & pop);
      fifo_pop  = pop & !byp;
   end

   // Fetch PC and in-flight tracking; redirect has top priority.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (redirect_valid) begin
         fetch_pc    <= redirect_target;
         inflight    <= 1'b0;
      end else if (issue) begin
         fetch_pc    <= fetch_pc + PC_W'(INSTR_BYTES);
         inflight    <= 1'b1;
         inflight_pc <= fetch_pc;
      end else begin
         inflight    <= 1'b0;
      end
   end

   sync_fifo_arstn #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .arst_n    (arst_n),
      .clear     (redirect_valid),
      .push      (fifo_push),
      .push_data ({inflight_pc, bus.imem_rdata}),
      .pop       (fifo_pop),
      .pop_data  (head_dat),
      .count     (fifo_count)
   );

   // Output drive: bypass word, queue head, or NOP/zero when idle.
   always_comb begin
      bus.imem_ren  = issue;
      bus.imem_addr = fetch_pc;
      bus.out_valid = head_vld | byp;
      bus.out_instr = INSTR_W'(NOP_INSTR);
      bus.out_pc    = '0;
      if (head_vld) begin
         bus.out_instr = head_dat[INSTR_W-1:0];
         bus.out_pc    = head_dat[ENTRY_W-1:INSTR_W];
      end else if (byp) begin
         bus.out_instr = bus.imem_rdata;
         bus.out_pc    = inflight_pc;
      end
   end

   assign count = fifo_count;

endmodule
